// File: rtl/accumulator_drain_unit.sv
// Drains finished accumulator tiles row by row, quantises each 32-lane row to int8
// and streams it into the unified buffer through a 2-entry output FIFO.
module accumulator_drain_unit #(
  parameter int MUL_SIZE = 32,
  parameter int ACC_W    = 32,
  parameter int DATA_W   = 8
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         start_i,
  input  logic [8:0]                   H_DIM_i,
  input  logic [8:0]                   W_DIM_i,
  input  logic [11:0]                  unified_buffer_start_addr_wr_i,
  input  logic                         relu_en_i,
  input  logic [4:0]                   shift_i,
  output logic                         read_accumulator_o,
  output logic [6:0]                   accumulator_addr_rd_o,
  input  logic [MUL_SIZE*ACC_W-1:0]    accumulator_data_i,
  output logic                         unified_buffer_wr_o,
  input  logic                         unified_buffer_ready_i,
  output logic [11:0]                  unified_buffer_addr_wr_o,
  output logic [MUL_SIZE*DATA_W-1:0]   unified_buffer_data_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam logic signed [ACC_W-1:0] Q_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] Q_MIN = ACC_W'(-(1 << (DATA_W - 1)));

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FLUSH} state_t;

  function automatic logic [DATA_W-1:0] quantise(input logic signed [ACC_W-1:0] acc,
                                                 input logic [4:0] sh,
                                                 input logic relu);
    logic signed [ACC_W-1:0] v;
    v = acc >>> sh;
    if (relu && (v < 0)) v = '0;
    if (v > Q_MAX)      v = Q_MAX;
    else if (v < Q_MIN) v = Q_MIN;
    return DATA_W'(v);
  endfunction

  state_t                       r_state;
  logic                         r_first;
  logic                         r_busy;
  logic                         r_done;
  logic                         r_relu;
  logic [4:0]                   r_shift;
  logic [8:0]                   r_rlast;
  logic [8:0]                   r_tlast;
  logic [8:0]                   r_r;
  logic [8:0]                   r_t;
  logic [6:0]                   r_stride;
  logic [6:0]                   r_base;
  logic [11:0]                  r_push_addr;
  logic                         r_inflight;
  logic [MUL_SIZE*DATA_W-1:0]   r_data_q [2];
  logic [11:0]                  r_addr_q [2];
  logic                         r_wptr;
  logic                         r_rptr;
  logic [1:0]                   r_occ;

  logic                         w_pop;
  logic                         w_push;
  logic [2:0]                   w_pending;
  logic                         w_issue;
  logic                         w_last_rd;
  logic [MUL_SIZE*DATA_W-1:0]   w_quant;

  assign w_pop     = (r_occ != 2'd0) && unified_buffer_ready_i;
  assign w_push    = r_inflight;
  // Entries still headed for the FIFO after this cycle; a new read may land at most two cycles out.
  assign w_pending = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue   = (r_state == S_DRAIN) && !r_first && (r_occ != 2'd2) && (w_pending < 3'd2);
  assign w_last_rd = (r_r == r_rlast) && (r_t == r_tlast);

  always_comb begin
    w_quant = '0;
    for (int i = 0; i < MUL_SIZE; i++) begin
      w_quant[i*DATA_W +: DATA_W] = quantise(accumulator_data_i[i*ACC_W +: ACC_W], r_shift, r_relu);
    end
  end

  assign read_accumulator_o       = w_issue;
  assign accumulator_addr_rd_o    = 7'(r_base + r_r);
  assign unified_buffer_wr_o      = (r_occ != 2'd0);
  assign unified_buffer_data_o    = r_data_q[r_rptr];
  assign unified_buffer_addr_wr_o = r_addr_q[r_rptr];
  assign busy_o                   = r_busy;
  assign done_o                   = r_done;

  // Control: issue side walks r inner, t outer; r_first spends one setup cycle after acceptance.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= S_IDLE;
      r_first     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_relu      <= 1'b0;
      r_shift     <= '0;
      r_rlast     <= '0;
      r_tlast     <= '0;
      r_r         <= '0;
      r_t         <= '0;
      r_stride    <= '0;
      r_base      <= '0;
      r_push_addr <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (w_push) r_push_addr <= r_push_addr + 12'd1;
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state     <= S_DRAIN;
            r_first     <= 1'b1;
            r_busy      <= 1'b1;
            r_relu      <= relu_en_i;
            r_shift     <= shift_i;
            r_rlast     <= H_DIM_i;
            r_tlast     <= W_DIM_i >> 5;
            r_stride    <= 7'(((H_DIM_i >> 5) + 9'd1) << 5);
            r_r         <= '0;
            r_t         <= '0;
            r_base      <= '0;
            r_push_addr <= unified_buffer_start_addr_wr_i;
          end
        end
        S_DRAIN: begin
          r_first <= 1'b0;
          if (w_issue) begin
            if (w_last_rd) begin
              r_state <= S_FLUSH;
            end else if (r_r == r_rlast) begin
              r_r    <= '0;
              r_t    <= r_t + 9'd1;
              r_base <= r_base + r_stride;
            end else begin
              r_r <= r_r + 9'd1;
            end
          end
        end
        S_FLUSH: begin
          // No reads in flight and one entry left: this pop is the final transfer.
          if (!r_inflight && (r_occ == 2'd1) && w_pop) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output FIFO: storage is cleared too so the write-side outputs read 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_wptr      <= 1'b0;
      r_rptr      <= 1'b0;
      r_occ       <= '0;
      r_data_q[0] <= '0;
      r_data_q[1] <= '0;
      r_addr_q[0] <= '0;
      r_addr_q[1] <= '0;
    end else begin
      if (w_push) begin
        r_data_q[r_wptr] <= w_quant;
        r_addr_q[r_wptr] <= r_push_addr;
        r_wptr           <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: tb/tb_accumulator_drain_unit.sv
// Scoreboard bench for accumulator_drain_unit: directed jobs queue expected reads/writes,
// a negedge monitor checks every strobe and write handshake against them.
module tb_accumulator_drain_unit;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic [8:0]    h_dim = '0;
  logic [8:0]    w_dim = '0;
  logic [11:0]   sa = '0;
  logic          relu = 1'b0;
  logic [4:0]    shift = '0;
  logic          rd_o;
  logic [6:0]    rd_addr;
  logic [1023:0] acc_data = '0;
  logic          wr_o;
  logic          ready = 1'b1;
  logic [11:0]   wr_addr;
  logic [255:0]  wr_data;
  logic          busy_o;
  logic          done_o;

  accumulator_drain_unit dut (
    .clk_i                          (clk),
    .rst_i                          (rst_i),
    .start_i                        (start_i),
    .H_DIM_i                        (h_dim),
    .W_DIM_i                        (w_dim),
    .unified_buffer_start_addr_wr_i (sa),
    .relu_en_i                      (relu),
    .shift_i                        (shift),
    .read_accumulator_o             (rd_o),
    .accumulator_addr_rd_o          (rd_addr),
    .accumulator_data_i             (acc_data),
    .unified_buffer_wr_o            (wr_o),
    .unified_buffer_ready_i         (ready),
    .unified_buffer_addr_wr_o       (wr_addr),
    .unified_buffer_data_o          (wr_data),
    .busy_o                         (busy_o),
    .done_o                         (done_o)
  );

  typedef struct {
    logic [11:0]  a;
    logic [255:0] d;
  } wr_t;

  wr_t           exp_wr[$];
  logic [6:0]    exp_rd[$];
  logic [1023:0] acc_mem [128];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int job_wr, job_rd, n_done, done_cyc, first_cyc, last_cyc, start_cyc;
  int tot_rd, tot_wr, prev_rd;
  bit hold_vld;
  logic [255:0] hold_d;
  logic [11:0]  hold_a;
  bit bp_mode = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1023:0] splat32(input int v);
    logic [1023:0] s;
    for (int i = 0; i < 32; i++) s[i*32 +: 32] = v;
    return s;
  endfunction

  function automatic logic [255:0] splat8(input int v);
    logic [255:0] s;
    for (int i = 0; i < 32; i++) s[i*8 +: 8] = v[7:0];
    return s;
  endfunction

  task automatic push_wr(input logic [11:0] a, input logic [255:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_wr.push_back(e);
  endtask

  // Accumulator bank model: row data appears the cycle after a strobe, poison otherwise.
  initial begin
    logic       s_rd;
    logic [6:0] s_addr;
    forever begin
      @(negedge clk);
      s_rd   = rd_o;
      s_addr = rd_addr;
      @(posedge clk);
      #1;
      acc_data = s_rd ? acc_mem[s_addr] : splat32(32'h55555555);
    end
  end

  // Ready driver: 1,0,0,1 pattern while backpressure is enabled.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode) ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      else         ready = 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    int  occ;
    wr_t e;
    forever begin
      @(negedge clk);
      if (rst_i === 1'b1) begin
        if (hold_vld) begin
          chk("hold_wr", wr_o, 1);
          chk("hold_data", wr_data, hold_d);
          chk("hold_addr", wr_addr, hold_a);
        end
        hold_vld = wr_o && !ready;
        if (hold_vld) begin
          hold_d = wr_data;
          hold_a = wr_addr;
        end
        if (rd_o) begin
          occ = tot_rd - prev_rd - tot_wr;
          chk("rd_while_fifo_full", occ >= 2, 0);
          if (exp_rd.size() == 0) chk("rd_unexpected", {1'b1, rd_addr}, 0);
          else                    chk("rd_addr", rd_addr, exp_rd.pop_front());
          job_rd++;
        end
        if (wr_o && ready) begin
          if (job_wr == 0) first_cyc = cyc;
          last_cyc = cyc;
          if (exp_wr.size() == 0) begin
            chk("wr_unexpected", {1'b1, wr_addr}, 0);
          end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", wr_addr, e.a);
            chk("wr_data", wr_data, e.d);
          end
          job_wr++;
        end
        if (done_o) begin
          n_done++;
          done_cyc = cyc;
        end
        tot_rd  += int'(rd_o);
        tot_wr  += int'(wr_o && ready);
        prev_rd  = int'(rd_o);
      end
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rd"}, rd_o, 0);
    chk({tag, "_rdaddr"}, rd_addr, 0);
    chk({tag, "_wr"}, wr_o, 0);
    chk({tag, "_wraddr"}, wr_addr, 0);
    chk({tag, "_wrdata"}, wr_data, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
  endtask

  task automatic kick(input logic [8:0] h, input logic [8:0] w, input logic [11:0] a,
                      input logic rl, input logic [4:0] sh);
    @(posedge clk);
    #1;
    h_dim = h; w_dim = w; sa = a; relu = rl; shift = sh;
    job_wr = 0; job_rd = 0; n_done = 0;
    start_i   = 1'b1;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    chk("busy_rise", busy_o, 1);
    // Scramble job inputs: the unit must work from the values latched at start.
    h_dim = 9'h1FF; w_dim = 9'h1FF; sa = 12'hABC; relu = 1'b1; shift = 5'd31;
  endtask

  task automatic run_job(input logic [8:0] h, input logic [8:0] w, input logic [11:0] a,
                         input logic rl, input logic [4:0] sh, input int n_rows,
                         input bit dbl_start, input bit chk_timing);
    kick(h, w, a, rl, sh);
    if (dbl_start) begin
      @(posedge clk);
      #1 start_i = 1'b1;
      @(posedge clk);
      #1 start_i = 1'b0;
    end
    for (int i = 0; i < 3000 && n_done == 0; i++) @(posedge clk);
    if (n_done == 0) chk("done_timeout", 0, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("done_pulses", n_done, 1);
    chk("write_count", job_wr, n_rows);
    chk("read_count", job_rd, n_rows);
    chk("exp_wr_left", exp_wr.size(), 0);
    chk("exp_rd_left", exp_rd.size(), 0);
    chk("busy_end", busy_o, 0);
    if (chk_timing) begin
      chk("first_wr_latency", first_cyc - start_cyc, 4);
      chk("wr_span", last_cyc - first_cyc, n_rows - 1);
      chk("done_latency", done_cyc - last_cyc, 1);
    end
  endtask

  task automatic load_rows_index();
    for (int r = 0; r < 32; r++) begin
      acc_mem[r] = splat32(r);
      exp_rd.push_back(7'(r));
      push_wr(12'h100 + 12'(r), splat8(r));
    end
  endtask

  initial begin
    logic [1023:0] row;
    logic [255:0]  e;
    logic [11:0]   wrap_a [4];
    int            a;
    int            v;

    for (int i = 0; i < 128; i++) acc_mem[i] = '0;
    hold_vld = 1'b0;
    tot_rd = 0; tot_wr = 0; prev_rd = 0;
    job_wr = 0; job_rd = 0; n_done = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    #2 rst_i = 1'b1;

    // Full 32x32 tile, lanes = row index
    load_rows_index();
    run_job(9'd31, 9'd31, 12'h100, 1'b0, 5'd0, 32, 1'b0, 1'b1);

    // Saturation without ReLU; a second start during busy must be ignored
    row = '0;
    row[0*32 +: 32] = 300;
    row[1*32 +: 32] = -300;
    row[2*32 +: 32] = -5;
    row[3*32 +: 32] = 127;
    row[31*32 +: 32] = -129;
    acc_mem[0] = row;
    e = '0;
    e[0 +: 8] = 8'd127; e[8 +: 8] = 8'h80; e[16 +: 8] = 8'hFB; e[24 +: 8] = 8'd127; e[248 +: 8] = 8'h80;
    exp_rd.push_back(7'd0);
    push_wr(12'h200, e);
    run_job(9'd0, 9'd0, 12'h200, 1'b0, 5'd0, 1, 1'b1, 1'b1);

    // Same lanes with ReLU
    e = '0;
    e[0 +: 8] = 8'd127; e[24 +: 8] = 8'd127;
    exp_rd.push_back(7'd0);
    push_wr(12'h210, e);
    run_job(9'd0, 9'd0, 12'h210, 1'b1, 5'd0, 1, 1'b0, 1'b0);

    // Arithmetic shift by 4
    row = '0;
    row[0*32 +: 32] = 1024;
    row[1*32 +: 32] = -1024;
    row[2*32 +: 32] = -1;
    row[3*32 +: 32] = 32'h7FFFFFFF;
    row[31*32 +: 32] = -129;
    acc_mem[0] = row;
    e = '0;
    e[0 +: 8] = 8'd64; e[8 +: 8] = 8'hC0; e[16 +: 8] = 8'hFF; e[24 +: 8] = 8'd127; e[248 +: 8] = 8'hF7;
    exp_rd.push_back(7'd0);
    push_wr(12'h220, e);
    run_job(9'd0, 9'd0, 12'h220, 1'b0, 5'd4, 1, 1'b0, 1'b0);

    // Backpressure: two column tiles of 8 rows, stride 32
    for (int k = 0; k < 16; k++) begin
      a = (k < 8) ? k : 32 + (k - 8);
      row = '0;
      e   = '0;
      for (int i = 0; i < 32; i++) begin
        v = a - 20 + i;
        row[i*32 +: 32] = v;
        e[i*8 +: 8]     = v[7:0];
      end
      acc_mem[a] = row;
      exp_rd.push_back(7'(a));
      push_wr(12'(k), e);
    end
    bp_mode = 1'b1;
    run_job(9'd7, 9'd40, 12'h000, 1'b0, 5'd0, 16, 1'b0, 1'b0);
    bp_mode = 1'b0;

    // Write address wrap
    wrap_a[0] = 12'hFFE; wrap_a[1] = 12'hFFF; wrap_a[2] = 12'h000; wrap_a[3] = 12'h001;
    for (int r = 0; r < 4; r++) begin
      acc_mem[r] = splat32(r + 100);
      exp_rd.push_back(7'(r));
      push_wr(wrap_a[r], splat8(r + 100));
    end
    run_job(9'd3, 9'd0, 12'hFFE, 1'b0, 5'd0, 4, 1'b0, 1'b0);

    // Asynchronous reset mid-drain
    load_rows_index();
    kick(9'd31, 9'd31, 12'h100, 1'b0, 5'd0);
    for (int i = 0; i < 500 && job_wr < 5; i++) @(posedge clk);
    if (job_wr < 5) chk("abort_wait", job_wr, 5);
    #3;
    chk("busy_before_abort", busy_o, 1);
    rst_i = 1'b0;
    #1;
    chk_zero_outputs("abort");
    exp_wr.delete();
    exp_rd.delete();
    tot_rd = 0; tot_wr = 0; prev_rd = 0;
    hold_vld = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("no_done_after_abort", n_done, 0);

    // Fresh drain after reset restarts from start + 0
    load_rows_index();
    run_job(9'd31, 9'd31, 12'h100, 1'b0, 5'd0, 32, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
